// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler: walks an M x COUT job in N x N output tiles (channel-inner, row-outer),
// issues one array multiply per tile, waits out streaming and drain, then hands each tile to a
// writeback consumer with a valid/ready handshake.
// Build option: define SA_SCHED_TIMEOUT_EN to enable the ARM+STREAM watchdog and the sticky err.
module sa_tile_scheduler #(
   parameter int unsigned N              = 64,
   parameter int unsigned DRAIN_CYCLES   = 128,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        go,
   input  logic [31:0] m_total,
   input  logic [31:0] cout_total,
   input  logic [31:0] x_base,
   input  logic [31:0] w_base,
   input  logic [31:0] x_row_stride,
   output logic [31:0] x_addr,
   output logic [31:0] w_addr,
   output logic        start_mul,
   input  logic        stall_mul,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] tile_m0,
   output logic [31:0] tile_c0,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStart,
      StArm,
      StStream,
      StDrain,
      StWb,
      StNext
   } state_t;

   state_t      state;

   // Job configuration captured on go; inputs are ignored for the rest of the job.
   logic [31:0] cfg_m_total;
   logic [31:0] cfg_cout_total;
   logic [31:0] cfg_x_base;
   logic [31:0] cfg_w_base;
   logic [31:0] cfg_x_row_stride;

   logic [31:0] drain_cnt;
   logic        timeout_hit;

   // One bit wider than the offsets so a tile step near 2^32 cannot wrap past the limit.
   logic [32:0] c0_inc;
   logic [32:0] m0_inc;
   logic        c0_wrap;
   logic        job_end;

   // Next-tile arithmetic for the NEXT state.
   always_comb begin
      c0_inc  = {1'b0, tile_c0} + 33'(N);
      m0_inc  = {1'b0, tile_m0} + 33'(N);
      c0_wrap = (c0_inc >= {1'b0, cfg_cout_total});
      job_end = c0_wrap && (m0_inc >= {1'b0, cfg_m_total});
   end

   // Main sequencer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state            <= StIdle;
         cfg_m_total      <= '0;
         cfg_cout_total   <= '0;
         cfg_x_base       <= '0;
         cfg_w_base       <= '0;
         cfg_x_row_stride <= '0;
         drain_cnt        <= '0;
         x_addr           <= '0;
         w_addr           <= '0;
         start_mul        <= 1'b0;
         wb_valid         <= 1'b0;
         tile_m0          <= '0;
         tile_c0          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         start_mul <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            StIdle: begin
               if (go) begin
                  cfg_m_total      <= m_total;
                  cfg_cout_total   <= cout_total;
                  cfg_x_base       <= x_base;
                  cfg_w_base       <= w_base;
                  cfg_x_row_stride <= x_row_stride;
                  tile_m0          <= '0;
                  tile_c0          <= '0;
                  // An empty job completes at once without touching the array.
                  if (m_total == '0 || cout_total == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= StSetup;
                  end
               end
            end
            StSetup: begin
               x_addr    <= cfg_x_base + tile_m0 * cfg_x_row_stride;
               w_addr    <= cfg_w_base + (tile_c0 << 2);
               start_mul <= 1'b1;
               state     <= StStart;
            end
            StStart: begin
               state <= StArm;
            end
            StArm: begin
               if (timeout_hit) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (stall_mul) begin
                  state <= StStream;
               end
            end
            StStream: begin
               if (timeout_hit) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (!stall_mul) begin
                  // The stall-low cycle counts as the first of the drain window.
                  if (DRAIN_CYCLES <= 1) begin
                     wb_valid <= 1'b1;
                     state    <= StWb;
                  end else begin
                     drain_cnt <= 32'(DRAIN_CYCLES - 1);
                     state     <= StDrain;
                  end
               end
            end
            StDrain: begin
               drain_cnt <= drain_cnt - 32'd1;
               if (drain_cnt <= 32'd1) begin
                  wb_valid <= 1'b1;
                  state    <= StWb;
               end
            end
            StWb: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  state    <= StNext;
               end
            end
            StNext: begin
               if (c0_wrap) begin
                  tile_c0 <= '0;
                  tile_m0 <= m0_inc[31:0];
               end else begin
                  tile_c0 <= c0_inc[31:0];
               end
               if (job_end) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  state <= StSetup;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

`ifdef SA_SCHED_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign timeout_hit = (state == StArm || state == StStream) &&
                        (to_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Watchdog over ARM+STREAM (zero elsewhere, so cleared by SETUP); err sticky until next go.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (state == StArm || state == StStream) begin
            to_cnt <= to_cnt + 32'd1;
         end else begin
            to_cnt <= '0;
         end
         if (state == StIdle && go) begin
            err <= 1'b0;
         end else if (timeout_hit) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler: tile order, addresses, drain latency, writeback
// back-pressure, ignored go/cfg mid-job, mid-job reset, empty job and (if built) the watchdog.
module tb_sa_tile_scheduler;

   localparam int unsigned N     = 64;
   localparam int unsigned DRAIN = 128;
   localparam int unsigned TMO   = 1000;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        go;
   logic [31:0] m_total;
   logic [31:0] cout_total;
   logic [31:0] x_base;
   logic [31:0] w_base;
   logic [31:0] x_row_stride;
   logic [31:0] x_addr;
   logic [31:0] w_addr;
   logic        start_mul;
   logic        stall_mul;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] tile_m0;
   logic [31:0] tile_c0;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int passes = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int wbv_cnt = 0;

   always #5 clk = ~clk;

   sa_tile_scheduler #(
      .N              (N),
      .DRAIN_CYCLES   (DRAIN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .go           (go),
      .m_total      (m_total),
      .cout_total   (cout_total),
      .x_base       (x_base),
      .w_base       (w_base),
      .x_row_stride (x_row_stride),
      .x_addr       (x_addr),
      .w_addr       (w_addr),
      .start_mul    (start_mul),
      .stall_mul    (stall_mul),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .tile_m0      (tile_m0),
      .tile_c0      (tile_c0),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   // Pulse counters sampled on the falling edge.
   always @(negedge clk) begin
      if (start_mul) start_cnt++;
      if (done) done_cnt++;
      if (wb_valid) wbv_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string pre);
      check({pre, "_x_addr"}, x_addr, 0);
      check({pre, "_w_addr"}, w_addr, 0);
      check({pre, "_start_mul"}, start_mul, 0);
      check({pre, "_wb_valid"}, wb_valid, 0);
      check({pre, "_tile_m0"}, tile_m0, 0);
      check({pre, "_tile_c0"}, tile_c0, 0);
      check({pre, "_busy"}, busy, 0);
      check({pre, "_done"}, done, 0);
      check({pre, "_err"}, err, 0);
   endtask

   task automatic go_pulse();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   // One tile from START through writeback; ends on the next START cycle or the done cycle.
   task automatic run_tile(input int stall_len, input int ready_delay, input bit ready_early,
                           input bit poke, input logic [31:0] em0, input logic [31:0] ec0,
                           input logic [31:0] ex, input logic [31:0] ew, input bit last);
      int n;
      n = 0;
      while (!start_mul && n < 50) begin
         tick();
         n++;
      end
      check("start_seen", start_mul, 1);
      check("x_addr", x_addr, ex);
      check("w_addr", w_addr, ew);
      check("start_m0", tile_m0, em0);
      check("start_c0", tile_c0, ec0);
      check("busy_in_job", busy, 1);
      tick();
      check("start_one_cycle", start_mul, 0);
      stall_mul = 1'b1;
      if (poke) begin
         go           = 1'b1;
         m_total      = 32'd1;
         cout_total   = 32'd1;
         x_base       = 32'hDEAD0000;
         w_base       = 32'hBEEF0000;
         x_row_stride = 32'd7;
      end
      tick();
      go = 1'b0;
      repeat (stall_len - 1) tick();
      check("x_addr_stable", x_addr, ex);
      stall_mul = 1'b0;
      if (ready_early) wb_ready = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!wb_valid && n < 1000);
      check("drain_latency", n, DRAIN);
      check("wb_m0", tile_m0, em0);
      check("wb_c0", tile_c0, ec0);
      for (int i = 0; i < ready_delay; i++) begin
         tick();
         check("wb_hold_valid", wb_valid, 1);
         check("wb_hold_m0", tile_m0, em0);
         check("wb_hold_c0", tile_c0, ec0);
      end
      wb_ready = 1'b1;
      tick();
      n = 1;
      check("wb_drop", wb_valid, 0);
      wb_ready = 1'b0;
      if (!last) begin
         while (!start_mul && n < 10) begin
            tick();
            n++;
         end
         check("next_start_gap", n, 3);
      end else begin
         while (!done && n < 10) begin
            tick();
            n++;
         end
         check("done_gap", n, 2);
         check("busy_end", busy, 0);
         tick();
         check("done_one_cycle", done, 0);
      end
   endtask

   initial begin
      int s0;
      int d0;
      int n;
      n_rst        = 1'b0;
      go           = 1'b0;
      stall_mul    = 1'b0;
      wb_ready     = 1'b0;
      m_total      = '0;
      cout_total   = '0;
      x_base       = '0;
      w_base       = '0;
      x_row_stride = '0;
      tick();
      tick();
      check_all_zero("reset");
      n_rst = 1'b1;
      tick();

      // Two tiles down the row axis; ready already high when WB is entered on tile 1.
      m_total      = 32'd128;
      cout_total   = 32'd32;
      x_base       = 32'h2000;
      w_base       = 32'h4000;
      x_row_stride = 32'h100;
      s0 = start_cnt;
      d0 = done_cnt;
      go_pulse();
      check("busy_after_go", busy, 1);
      run_tile(370, 0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h4000, 1'b0);
      run_tile(370, 0, 1'b0, 1'b0, 32'd64, 32'd0, 32'h6000, 32'h4000, 1'b1);
      repeat (5) tick();
      check("a_start_count", start_cnt - s0, 2);
      check("a_done_count", done_cnt - d0, 1);
      check("a_busy_low", busy, 0);

      // Four tiles channel-inner; back-pressure and go/cfg poke on tile 2.
      m_total      = 32'd128;
      cout_total   = 32'd128;
      x_base       = 32'h1000;
      w_base       = 32'h8000;
      x_row_stride = 32'h5AC;
      s0 = start_cnt;
      d0 = done_cnt;
      go_pulse();
      run_tile(370, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h8000, 1'b0);
      run_tile(370, 20, 1'b0, 1'b1, 32'd0, 32'd64, 32'h1000, 32'h8100, 1'b0);
      run_tile(370, 0, 1'b0, 1'b0, 32'd64, 32'd0, 32'h17B00, 32'h8000, 1'b0);
      run_tile(370, 0, 1'b0, 1'b0, 32'd64, 32'd64, 32'h17B00, 32'h8100, 1'b1);
      repeat (5) tick();
      check("b_start_count", start_cnt - s0, 4);
      check("b_done_count", done_cnt - d0, 1);

      // Reset during STREAM of tile 1.
      m_total      = 32'd128;
      cout_total   = 32'd128;
      x_base       = 32'h1000;
      w_base       = 32'h8000;
      x_row_stride = 32'h5AC;
      go_pulse();
      n = 0;
      while (!start_mul && n < 50) begin
         tick();
         n++;
      end
      check("r_start_seen", start_mul, 1);
      tick();
      stall_mul = 1'b1;
      repeat (10) tick();
      d0 = done_cnt;
      n_rst = 1'b0;
      tick();
      n_rst     = 1'b1;
      stall_mul = 1'b0;
      check_all_zero("midreset");
      repeat (5) tick();
      check("r_no_done", done_cnt - d0, 0);
      check("r_idle_busy", busy, 0);

      // Restart from (0,0) with a single partial tile.
      m_total      = 32'd64;
      cout_total   = 32'd40;
      x_base       = 32'h3000;
      w_base       = 32'h9000;
      x_row_stride = 32'd4;
      go_pulse();
      run_tile(370, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h3000, 32'h9000, 1'b1);

      // Empty job: done next cycle, no array start.
      s0 = start_cnt;
      m_total = 32'd0;
      go_pulse();
      check("z_done", done, 1);
      check("z_busy", busy, 0);
      tick();
      check("z_done_one_cycle", done, 0);
      repeat (5) tick();
      check("z_no_start", start_cnt - s0, 0);

`ifdef SA_SCHED_TIMEOUT_EN
      // Stall stuck high: watchdog ends the job with err and no writeback.
      m_total    = 32'd64;
      cout_total = 32'd64;
      d0 = wbv_cnt;
      go_pulse();
      n = 0;
      while (!start_mul && n < 50) begin
         tick();
         n++;
      end
      stall_mul = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 3000);
      check("t_timeout_cycle", n, TMO + 1);
      check("t_err", err, 1);
      check("t_busy", busy, 0);
      check("t_no_wb", wbv_cnt - d0, 0);
      stall_mul = 1'b0;
      tick();
      check("t_err_sticky", err, 1);
      go_pulse();
      check("t_err_cleared", err, 0);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
`else
      check("err_tied_low", err, 0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
